ppu_frame_scheduler: RTL and testbench



---
 rtl/ppu_pkg.sv | 20 ++
 rtl/ppu_tile_counter.sv | 51 +++++
 rtl/ppu_frame_scheduler.sv | 164 ++++++++++++++++
 tb/tb_ppu_frame_scheduler.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// ppu_pkg: definitions shared by the PPU frame scheduler and its tile counter.
//   state_t      - scheduler FSM states (IDLE, SYNC, WAIT_PIX, ACK, PUSH)
//   MODE_W       - width of the PPU mode field
//   DEF_H_TILES  - default pixels per line
//   DEF_V_TILES  - default lines per frame
package ppu_pkg;

    localparam int MODE_W      = 3;
    localparam int DEF_H_TILES = 32;
    localparam int DEF_V_TILES = 32;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SYNC     = 3'd1,
        ST_WAIT_PIX = 3'd2,
        ST_ACK      = 3'd3,
        ST_PUSH     = 3'd4
    } state_t;

endpackage

// File: rtl/ppu_tile_counter.sv
// ppu_tile_counter: x/y raster position inside a tile frame.
//   clk, rst    - clock, asynchronous active-high reset
//   clear       - return to (0,0)
//   advance     - step one pixel: x wraps at H_TILES-1 and carries into y,
//                 y wraps at V_TILES-1
//   x, y        - current pixel column and line
//   last_pixel  - high while (x,y) is the final pixel of the frame
module ppu_tile_counter
    import ppu_pkg::*;
#(
    parameter int H_TILES = DEF_H_TILES,
    parameter int V_TILES = DEF_V_TILES,
    parameter int CNT_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             last_pixel
);

    localparam logic [CNT_W-1:0] X_MAX = CNT_W'(H_TILES - 1);
    localparam logic [CNT_W-1:0] Y_MAX = CNT_W'(V_TILES - 1);

    logic end_of_line;
    logic end_of_frame;

    assign end_of_line  = (x == X_MAX);
    assign end_of_frame = (y == Y_MAX);
    assign last_pixel   = end_of_line && end_of_frame;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (end_of_line) begin
                x <= '0;
                y <= end_of_frame ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ppu_frame_scheduler.sv
// ppu_frame_scheduler: drives one PPU through H_TILES x V_TILES pixel frames.
//   clk, rst               - clock, asynchronous active-high reset
//   enable                 - run frames back to back while high; a frame in
//                            progress always completes
//   cfg_we/cfg_mode        - write the pending mode (applied at next frame start)
//   cfg_clr                - with cfg_we, clear the sticky timeout_err
//   sync, mode             - frame-start pulse and active mode towards the PPU
//   pix_stb/pix_data/pix_ack - PPU output handshake
//   out_valid/out_ready, out_data/out_x/out_y - tagged pixel stream to sink
//   frame_cnt              - completed frames (8-bit, wraps)
//   busy                   - scheduler not idle
//   timeout_err            - a PPU stall forced a FILL pixel
module ppu_frame_scheduler
    import ppu_pkg::*;
#(
    parameter int         H_TILES = DEF_H_TILES,
    parameter int         V_TILES = DEF_V_TILES,
    parameter int         CNT_W   = 5,
    parameter int         TIMEOUT = 15,
    parameter logic [7:0] FILL    = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              cfg_we,
    input  logic [MODE_W-1:0] cfg_mode,
    input  logic              cfg_clr,
    output logic              sync,
    output logic [MODE_W-1:0] mode,
    input  logic              pix_stb,
    input  logic [7:0]        pix_data,
    output logic              pix_ack,
    output logic              out_valid,
    output logic [7:0]        out_data,
    output logic [CNT_W-1:0]  out_x,
    output logic [CNT_W-1:0]  out_y,
    input  logic              out_ready,
    output logic [7:0]        frame_cnt,
    output logic              busy,
    output logic              timeout_err
);

    localparam int TCNT_W = $clog2(TIMEOUT + 1);

    state_t              state;
    logic [MODE_W-1:0]   pending_mode;
    logic [TCNT_W-1:0]   tcnt;
    logic                transfer;
    logic                timeout_hit;
    logic                last_pixel;

    // out_valid is high throughout PUSH, so a transfer is PUSH with ready.
    assign transfer    = (state == ST_PUSH) && out_ready;
    assign timeout_hit = (state == ST_WAIT_PIX) && !pix_stb &&
                         (tcnt == TCNT_W'(TIMEOUT));

    // The counter registers are the presented coordinates; they only move
    // on a transfer and are re-zeroed in SYNC.
    ppu_tile_counter #(
        .H_TILES (H_TILES),
        .V_TILES (V_TILES),
        .CNT_W   (CNT_W)
    ) u_tile_counter (
        .clk        (clk),
        .rst        (rst),
        .clear      (state == ST_SYNC),
        .advance    (transfer),
        .x          (out_x),
        .y          (out_y),
        .last_pixel (last_pixel)
    );

    // Config: a write in the SYNC cycle lands after mode has sampled
    // pending_mode, so it is deferred to the next frame. A timeout in the
    // same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_mode <= '0;
            timeout_err  <= 1'b0;
        end else begin
            if (cfg_we) begin
                pending_mode <= cfg_mode;
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end else if (cfg_we && cfg_clr) begin
                timeout_err <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            sync      <= 1'b0;
            mode      <= '0;
            pix_ack   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            frame_cnt <= '0;
            busy      <= 1'b0;
            tcnt      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state <= ST_SYNC;
                        sync  <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                ST_SYNC: begin
                    sync  <= 1'b0;
                    mode  <= pending_mode;
                    tcnt  <= '0;
                    state <= ST_WAIT_PIX;
                end
                ST_WAIT_PIX: begin
                    if (pix_stb) begin
                        out_data <= pix_data;
                        pix_ack  <= 1'b1;
                        tcnt     <= '0;
                        state    <= ST_ACK;
                    end else if (timeout_hit) begin
                        // Stalled PPU: present FILL without acknowledging.
                        out_data  <= FILL;
                        out_valid <= 1'b1;
                        tcnt      <= '0;
                        state     <= ST_PUSH;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                ST_ACK: begin
                    pix_ack   <= 1'b0;
                    out_valid <= 1'b1;
                    state     <= ST_PUSH;
                end
                ST_PUSH: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (last_pixel) begin
                            frame_cnt <= frame_cnt + 1'b1;
                            if (enable) begin
                                state <= ST_SYNC;
                                sync  <= 1'b1;
                            end else begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            state <= ST_WAIT_PIX;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ppu_frame_scheduler.sv
// tb_ppu_frame_scheduler: drives the scheduler as PPU and sink with random
// and directed traffic, and compares every output each cycle against a
// procedural frame/pixel model.
module tb_ppu_frame_scheduler;

    localparam int         H     = 32;
    localparam int         V     = 32;
    localparam int         CW    = 5;
    localparam int         TO    = 15;
    localparam logic [7:0] FILLV = 8'h00;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          cfg_we = 1'b0;
    logic [2:0]    cfg_mode = 3'd0;
    logic          cfg_clr = 1'b0;
    logic          sync;
    logic [2:0]    mode;
    logic          pix_stb = 1'b0;
    logic [7:0]    pix_data = 8'h00;
    logic          pix_ack;
    logic          out_valid;
    logic [7:0]    out_data;
    logic [CW-1:0] out_x;
    logic [CW-1:0] out_y;
    logic          out_ready = 1'b0;
    logic [7:0]    frame_cnt;
    logic          busy;
    logic          timeout_err;

    ppu_frame_scheduler #(
        .H_TILES (H),
        .V_TILES (V),
        .CNT_W   (CW),
        .TIMEOUT (TO),
        .FILL    (FILLV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .cfg_we      (cfg_we),
        .cfg_mode    (cfg_mode),
        .cfg_clr     (cfg_clr),
        .sync        (sync),
        .mode        (mode),
        .pix_stb     (pix_stb),
        .pix_data    (pix_data),
        .pix_ack     (pix_ack),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_x       (out_x),
        .out_y       (out_y),
        .out_ready   (out_ready),
        .frame_cnt   (frame_cnt),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (miscompares <= 40)
                $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic       e_sync = 1'b0, e_ack = 1'b0, e_valid = 1'b0, e_busy = 1'b0, e_err = 1'b0;
    logic [2:0] e_mode = 3'd0, m_pending = 3'd0;
    logic [7:0] e_data = 8'h00, e_frame = 8'h00;
    int         e_x = 0, e_y = 0;
    int         transfers = 0;

    // Config effects of one clock edge; inputs are still the pre-edge values.
    task automatic cfg_step(input bit is_sync, input bit to_now);
        if (is_sync) e_mode = m_pending;
        if (to_now) e_err = 1'b1;
        else if (cfg_we && cfg_clr) e_err = 1'b0;
        if (cfg_we) m_pending = cfg_mode;
    endtask

    // Entered right after the edge that starts the sync cycle.
    task automatic run_frame(output bit cont);
        int t;
        bit got;
        bit r;
        logic [7:0] d;
        cont = 1'b0;
        e_sync = 1'b1;
        e_busy = 1'b1;
        @(posedge clk);
        cfg_step(1'b1, 1'b0);
        e_sync = 1'b0;
        e_x = 0;
        e_y = 0;
        for (int k = 0; k < H * V; k++) begin
            t = 0;
            got = 1'b0;
            d = FILLV;
            while (1) begin
                @(posedge clk);
                if (pix_stb === 1'b1) begin
                    got = 1'b1;
                    d = pix_data;
                    cfg_step(1'b0, 1'b0);
                    break;
                end
                if (t == TO) begin
                    cfg_step(1'b0, 1'b1);
                    break;
                end
                t++;
                cfg_step(1'b0, 1'b0);
            end
            if (got) begin
                e_data = d;
                e_ack = 1'b1;
                @(posedge clk);
                cfg_step(1'b0, 1'b0);
                e_ack = 1'b0;
            end else begin
                e_data = FILLV;
            end
            e_valid = 1'b1;
            do begin
                @(posedge clk);
                r = out_ready;
                cfg_step(1'b0, 1'b0);
            end while (!r);
            e_valid = 1'b0;
            transfers++;
            if (k == H * V - 1) begin
                e_frame = e_frame + 8'd1;
                cont = enable;
                if (!cont) e_busy = 1'b0;
                e_x = 0;
                e_y = 0;
            end else begin
                e_x = (k + 1) % H;
                e_y = (k + 1) / H;
            end
        end
    endtask

    initial begin : model
        bit go;
        @(negedge rst);
        forever begin
            e_busy = 1'b0;
            go = 1'b0;
            while (!go) begin
                @(posedge clk);
                go = enable;
                cfg_step(1'b0, 1'b0);
            end
            do run_frame(go); while (go);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("sync", 32'(sync), 32'(e_sync));
            check("mode", 32'(mode), 32'(e_mode));
            check("pix_ack", 32'(pix_ack), 32'(e_ack));
            check("out_valid", 32'(out_valid), 32'(e_valid));
            check("frame_cnt", 32'(frame_cnt), 32'(e_frame));
            check("busy", 32'(busy), 32'(e_busy));
            check("timeout_err", 32'(timeout_err), 32'(e_err));
            check("out_x", 32'(out_x), 32'(e_x));
            check("out_y", 32'(out_y), 32'(e_y));
            if (e_valid) check("out_data", 32'(out_data), 32'(e_data));
        end
    end

    // ---------------- stimulus ----------------
    bit rnd_mode = 1'b0, force_ready_low = 1'b0, force_stb_low = 1'b0;
    int cyc = 0;

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        cfg_we = 1'b0;
        cfg_clr = 1'b0;
        pix_data = 8'($urandom);
        if (force_stb_low) pix_stb = 1'b0;
        else if (rnd_mode) pix_stb = ($urandom_range(0, 9) < 6);
        else pix_stb = 1'b1;
        if (force_ready_low) out_ready = 1'b0;
        else if (rnd_mode && !force_stb_low) out_ready = ($urandom_range(0, 9) < 6);
        else out_ready = 1'b1;
    endtask

    initial begin : main
        int n;
        int t1;
        int acks;
        int syncs;

        repeat (3) cycle();
        check("rst_sync", 32'(sync), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk_en = 1'b1;
        rst = 1'b0;
        cycle();
        enable = 1'b1;

        // Frame 1: full throughput, mid-frame mode write.
        n = 0;
        while (sync !== 1'b1 && n < 10) begin cycle(); n++; end
        check("first_sync", 32'(sync), 32'd1);
        t1 = cyc;
        repeat (100) cycle();
        cfg_we = 1'b1;
        cfg_mode = 3'd3;
        cycle();
        cycle();
        check("mode_mid_frame", 32'(mode), 32'd0);
        n = 0;
        while (sync !== 1'b1 && n < 4000) begin cycle(); n++; end
        check("sync_interval", 32'(cyc - t1), 32'd3073);
        check("frame1_cnt", 32'(frame_cnt), 32'd1);
        check("frame1_transfers", 32'(transfers), 32'd1024);
        // Write coincident with SYNC: this frame still gets mode 3.
        cfg_we = 1'b1;
        cfg_mode = 3'd5;
        cycle();
        check("mode_after_sync", 32'(mode), 32'd3);

        // Frame 2: random traffic, sink stall, PPU stall.
        rnd_mode = 1'b1;
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin cycle(); n++; end
        check("valid_before_stall", 32'(out_valid), 32'd1);
        out_ready = 1'b0;
        force_ready_low = 1'b1;
        acks = 0;
        repeat (10) begin
            cycle();
            if (pix_ack === 1'b1) acks++;
        end
        check("valid_held_stall", 32'(out_valid), 32'd1);
        check("acks_during_stall", 32'(acks), 32'd0);
        force_ready_low = 1'b0;

        force_stb_low = 1'b1;
        pix_stb = 1'b0;
        out_ready = 1'b1;
        repeat (20) cycle();
        check("timeout_set", 32'(timeout_err), 32'd1);
        force_stb_low = 1'b0;
        repeat (5) cycle();
        check("timeout_sticky", 32'(timeout_err), 32'd1);
        cfg_we = 1'b1;
        cfg_clr = 1'b1;
        cfg_mode = 3'd5;
        cycle();
        cycle();
        check("timeout_cleared", 32'(timeout_err), 32'd0);

        n = 0;
        while (frame_cnt !== 8'd2 && n < 30000) begin cycle(); n++; end
        check("frame2_cnt", 32'(frame_cnt), 32'd2);
        rnd_mode = 1'b0;
        cycle();
        cycle();
        check("mode_deferred", 32'(mode), 32'd5);

        // Frame 3: enable dropped mid-frame.
        n = 0;
        while (!(out_valid === 1'b1 && out_x == 5'd5 && out_y == 5'd3) && n < 2000) begin
            cycle();
            n++;
        end
        check("reached_5_3", 32'({out_y, out_x}), 32'({5'd3, 5'd5}));
        enable = 1'b0;
        n = 0;
        while (busy !== 1'b0 && n < 5000) begin cycle(); n++; end
        check("idle_busy", 32'(busy), 32'd0);
        check("frame3_cnt", 32'(frame_cnt), 32'd3);
        check("total_transfers", 32'(transfers), 32'd3072);
        syncs = 0;
        repeat (20) begin
            cycle();
            if (sync === 1'b1) syncs++;
        end
        check("no_sync_idle", 32'(syncs), 32'd0);

        // Async reset during ACK, with a timeout flagged first.
        enable = 1'b1;
        force_stb_low = 1'b1;
        pix_stb = 1'b0;
        repeat (20) cycle();
        force_stb_low = 1'b0;
        check("timeout_before_rst", 32'(timeout_err), 32'd1);
        n = 0;
        while (pix_ack !== 1'b1 && n < 100) begin cycle(); n++; end
        check("ack_before_rst", 32'(pix_ack), 32'd1);
        chk_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_pix_ack", 32'(pix_ack), 32'd0);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_sync", 32'(sync), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("arst_timeout_err", 32'(timeout_err), 32'd0);
        check("arst_xy", 32'({out_y, out_x}), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
